ddrx_refresh_sched: RTL and testbench
=====================================

Name: ddrx_refresh_sched

Overview:
- Refresh scheduler for the DDRx controller core, in the core_clk domain.
- Generates the periodic refresh obligation and tracks refresh debt. Postponement follows JEDEC rules.
- When a refresh is due, it blocks new traffic and sequences PREA → tRP → REF → tRFC through the DFI command mux.
- Refreshes are normally opportunistic, issued when the scheduler is idle. Once debt nears its limit they become forced, regardless of traffic.

Parameters:
- C_TREFI_W, 16: width of the tREFI interval counter and cfg_trefi.
- C_TRFC_W, 10: width of the tRFC wait counter and cfg_trfc.
- C_TRP_W, 6: width of the tRP wait counter and cfg_trp.
- C_MAX_POSTPONE, 8: maximum outstanding refresh debt, legal range 2..8.
- C_CNT_W, 4: width of ref_pending, equal to clog2(C_MAX_POSTPONE+1).

Ports:
- core_clk, in, 1: core clock.
- core_arstn, in, 1: asynchronous active-low reset.
- cfg_en, in, 1: refresh enable (from NASTI-Lite regs, already synchronised).
- cfg_trefi, in, C_TREFI_W: tREFI in core_clk cycles; 0 means no ticks.
- cfg_trfc, in, C_TRFC_W: tRFC in cycles.
- cfg_trp, in, C_TRP_W: tRP in cycles.
- sched_idle, in, 1: main scheduler has no queued NASTI work.
- bank_open, in, 1: at least one bank is open.
- ref_block, out, 1: main scheduler must issue no new ACT/RD/WR.
- ref_urgent, out, 1: ref_pending ≥ C_MAX_POSTPONE-1.
- cmd_valid, out, 1: command request to DFI command mux.
- cmd_ready, in, 1: mux accepts the command this cycle.
- cmd_is_ref, out, 1: 1 = REF, 0 = PREA (all banks).
- ref_pending, out, C_CNT_W: current refresh debt.
- err_overflow, out, 1: sticky flag; debt exceeded C_MAX_POSTPONE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, interval counter loaded with cfg_trefi-1 on the first enabled cycle.
- Interval counter:
  - Counts down while cfg_en=1 and cfg_trefi≠0.
  - On reaching 0: one-cycle tick, then reload cfg_trefi-1. Tick period is exactly cfg_trefi cycles.
  - While cfg_en=0 or cfg_trefi=0: counter held at cfg_trefi-1 and no ticks.
- ref_pending:
  - Tick: +1.
  - REF handshake (cmd_valid & cmd_ready & cmd_is_ref): −1.
  - Both in the same cycle: unchanged.
  - Tick while already at C_MAX_POSTPONE: value saturates and err_overflow is set. err_overflow clears only on reset.
- FSM states: IDLE, DRAIN, PREA, WAIT_RP, REF, WAIT_RFC.
- IDLE:
  - Start condition: ref_pending>0 and (sched_idle or ref_urgent) and cfg_en. When met, go to DRAIN and assert ref_block.
  - cfg_en=0 prevents any new sequence from starting.
- DRAIN: one cycle, letting in-flight commands from the scheduler land. Go to PREA if bank_open, else to REF.
- PREA: cmd_valid=1, cmd_is_ref=0. Hold until cmd_ready, then go to WAIT_RP.
- WAIT_RP: wait max(cfg_trp,1) cycles, then go to REF.
- REF: cmd_valid=1, cmd_is_ref=1. Hold until cmd_ready, then go to WAIT_RFC.
- WAIT_RFC: wait max(cfg_trfc,1) cycles.
  - On expiry: if ref_pending>0 and ref_urgent, go back-to-back to REF, skipping DRAIN/PREA because all banks are closed.
  - Otherwise return to IDLE and deassert ref_block in that same cycle.
- ref_block is 1 in every state except IDLE.
- cmd_valid may only drop after a handshake. cmd_is_ref is stable while cmd_valid=1.
- cfg_en falling mid-sequence: the current sequence completes normally, then the FSM stays in IDLE. ref_pending is held, not cleared.
- cfg_* values are sampled at the point of use (counter load); changing them mid-wait does not affect the current wait.
- Async reset mid-sequence: immediate return to reset state. No command may be left half-handshaken from this block's side.

Decomposition:
- Shared package ddrx_mc_pkg:
  - typedef ref_state_e.
  - Constants C_MAX_POSTPONE_DEF and the JEDEC bound 8.
  - The DFI command encoding used by the command mux (PREA/REF opcodes).
- One natural sub-module, ddrx_wait_cnt: a loadable down-counter with a done pulse. It is instantiated twice: for the tREFI interval and, shared, for the tRP/tRFC waits.

Test Plan:
- cfg_trefi=100, cfg_trfc=20, cfg_trp=5, sched_idle=1, bank_open=1, cmd_ready=1 → ticks at cycles 100, 200, …
  - Each tick yields DRAIN → PREA → 5-cycle wait → REF → 20-cycle wait.
  - ref_pending returns to 0; ref_block high for 29 cycles per refresh.
- sched_idle=0, cfg_trefi=10, no other stimulus → ref_pending climbs 1..7.
  - ref_urgent asserts at 7 and forces a sequence; ref_pending decrements back below 7 via back-to-back REFs.
- cmd_ready held 0 for 50 cycles during REF with C_MAX_POSTPONE=8, cfg_trefi=5 → ref_pending saturates at 8 and err_overflow is set.
  - cmd_valid/cmd_is_ref stay stable throughout.
- Tick coincident with REF handshake, ref_pending=3 → ref_pending stays 3.
- bank_open=0 at DRAIN → no PREA is issued; REF is issued directly one cycle after DRAIN.
- core_arstn asserted during WAIT_RFC, then cfg_en dropped mid-PREA on a later run → reset zeroes all outputs immediately.
  - After cfg_en drops: PREA, REF and WAIT_RFC complete, the FSM then idles, and ref_pending is retained.

Source files
------------

// File: rtl/ddrx_mc_pkg.sv
// Shared definitions for the DDRx memory-controller core: refresh FSM states,
// postponement limits and the DFI command opcodes used by the command mux.
package ddrx_mc_pkg;

  localparam int C_MAX_POSTPONE_DEF   = 8;
  localparam int C_JEDEC_MAX_POSTPONE = 8;

  typedef enum logic [2:0] {
    REF_IDLE,
    REF_DRAIN,
    REF_PREA,
    REF_WAIT_RP,
    REF_REF,
    REF_WAIT_RFC
  } ref_state_e;

  // {ras_n, cas_n, we_n} with cs_n low
  typedef enum logic [2:0] {
    DFI_CMD_REF  = 3'b001,
    DFI_CMD_PREA = 3'b010,
    DFI_CMD_NOP  = 3'b111
  } dfi_cmd_e;

endpackage

// File: rtl/ddrx_wait_cnt.sv
// Loadable down-counter: done pulses for one cycle when the count reaches zero
// while enabled, and the counter then reloads from load_val.
module ddrx_wait_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  assign done = en & ~load & (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load || done) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/ddrx_refresh_sched.sv
// Refresh scheduler: tracks tREFI debt and sequences PREA -> tRP -> REF -> tRFC,
// opportunistically when the main scheduler is idle, forcibly when debt is urgent.
module ddrx_refresh_sched
  import ddrx_mc_pkg::*;
#(
  parameter int C_TREFI_W      = 16,
  parameter int C_TRFC_W       = 10,
  parameter int C_TRP_W        = 6,
  parameter int C_MAX_POSTPONE = C_MAX_POSTPONE_DEF,
  parameter int C_CNT_W        = $clog2(C_MAX_POSTPONE + 1)
) (
  input  logic                 core_clk,
  input  logic                 core_arstn,
  input  logic                 cfg_en,
  input  logic [C_TREFI_W-1:0] cfg_trefi,
  input  logic [C_TRFC_W-1:0]  cfg_trfc,
  input  logic [C_TRP_W-1:0]   cfg_trp,
  input  logic                 sched_idle,
  input  logic                 bank_open,
  output logic                 ref_block,
  output logic                 ref_urgent,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 cmd_is_ref,
  output logic [C_CNT_W-1:0]   ref_pending,
  output logic                 err_overflow
);

  localparam int C_MAXP   = (C_MAX_POSTPONE > C_JEDEC_MAX_POSTPONE) ? C_JEDEC_MAX_POSTPONE
                                                                      : C_MAX_POSTPONE;
  localparam int C_WAIT_W = (C_TRFC_W > C_TRP_W) ? C_TRFC_W : C_TRP_W;

  ref_state_e state, state_nxt;
  logic       run, armed, tick, start, ref_hs, wait_load, wait_en, wait_done;
  logic [C_TREFI_W-1:0] trefi_m1;
  logic [C_WAIT_W-1:0]  trp_m1, trfc_m1, wait_val;

  // The interval counter is reloaded on the first enabled cycle and whenever disabled
  assign run      = cfg_en & (cfg_trefi != '0);
  assign trefi_m1 = cfg_trefi - C_TREFI_W'(1);

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) armed <= 1'b0;
    else             armed <= run;
  end

  ddrx_wait_cnt #(.W(C_TREFI_W)) u_trefi_cnt (
    .clk      (core_clk),
    .rst_n    (core_arstn),
    .load     (~(run & armed)),
    .en       (run & armed),
    .load_val (trefi_m1),
    .done     (tick)
  );

  // One counter serves both tRP and tRFC; it is loaded at the command handshake
  assign trp_m1    = (cfg_trp  == '0) ? '0 : C_WAIT_W'(cfg_trp)  - C_WAIT_W'(1);
  assign trfc_m1   = (cfg_trfc == '0) ? '0 : C_WAIT_W'(cfg_trfc) - C_WAIT_W'(1);
  assign wait_val  = (state == REF_REF) ? trfc_m1 : trp_m1;
  assign wait_load = cmd_valid & cmd_ready;
  assign wait_en   = (state == REF_WAIT_RP) || (state == REF_WAIT_RFC);

  ddrx_wait_cnt #(.W(C_WAIT_W)) u_wait_cnt (
    .clk      (core_clk),
    .rst_n    (core_arstn),
    .load     (wait_load),
    .en       (wait_en),
    .load_val (wait_val),
    .done     (wait_done)
  );

  assign ref_urgent = (ref_pending >= C_CNT_W'(C_MAXP - 1));
  assign ref_hs     = cmd_valid & cmd_ready & cmd_is_ref;

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      ref_pending  <= '0;
      err_overflow <= 1'b0;
    end else if (tick && !ref_hs) begin
      if (ref_pending == C_CNT_W'(C_MAXP)) err_overflow <= 1'b1;
      else                                 ref_pending  <= ref_pending + C_CNT_W'(1);
    end else if (ref_hs && !tick && ref_pending != '0) begin
      ref_pending <= ref_pending - C_CNT_W'(1);
    end
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) state <= REF_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    unique case (state)
      REF_IDLE: begin
        if (cfg_en && ref_pending != '0 && (sched_idle || ref_urgent)) begin
          start     = 1'b1;
          state_nxt = REF_DRAIN;
        end
      end
      REF_DRAIN:    state_nxt = bank_open ? REF_PREA : REF_REF;
      REF_PREA:     if (cmd_ready) state_nxt = REF_WAIT_RP;
      REF_WAIT_RP:  if (wait_done) state_nxt = REF_REF;
      REF_REF:      if (cmd_ready) state_nxt = REF_WAIT_RFC;
      // All banks are already closed here, so an urgent follow-up goes straight to REF
      REF_WAIT_RFC: if (wait_done) state_nxt = (ref_pending != '0 && ref_urgent) ? REF_REF
                                                                                   : REF_IDLE;
      default:      state_nxt = REF_IDLE;
    endcase
  end

  assign ref_block  = (state != REF_IDLE) | start;
  assign cmd_valid  = (state == REF_PREA) || (state == REF_REF);
  assign cmd_is_ref = (state == REF_REF);

endmodule

// File: tb/tb_ddrx_refresh_sched.sv
// Self-checking bench for ddrx_refresh_sched against a queue-based schedule model.
module tb_ddrx_refresh_sched;

  localparam int MAXP = 8;

  logic        core_clk = 1'b0;
  logic        core_arstn = 1'b0;
  logic        cfg_en = 1'b0, sched_idle = 1'b0, bank_open = 1'b0, cmd_ready = 1'b0;
  logic [15:0] cfg_trefi = '0;
  logic [9:0]  cfg_trfc = '0;
  logic [5:0]  cfg_trp = '0;
  logic        ref_block, ref_urgent, cmd_valid, cmd_is_ref, err_overflow;
  logic [3:0]  ref_pending;

  int n_pass = 0, n_checks = 0;

  ddrx_refresh_sched #(
    .C_TREFI_W(16), .C_TRFC_W(10), .C_TRP_W(6), .C_MAX_POSTPONE(MAXP), .C_CNT_W(4)
  ) dut (
    .core_clk(core_clk), .core_arstn(core_arstn), .cfg_en(cfg_en), .cfg_trefi(cfg_trefi),
    .cfg_trfc(cfg_trfc), .cfg_trp(cfg_trp), .sched_idle(sched_idle), .bank_open(bank_open),
    .ref_block(ref_block), .ref_urgent(ref_urgent), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_is_ref(cmd_is_ref), .ref_pending(ref_pending),
    .err_overflow(err_overflow)
  );

  always #5 core_clk = ~core_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: debt as an integer, ticks as absolute cycle numbers, and the refresh
  // sequence as a queue of planned per-cycle steps consumed one per clock.
  typedef enum int {S_DRAIN, S_PREA, S_WAIT, S_REF, S_RFC_LAST} step_e;
  step_e      plan[$];
  int         m_pend, m_cyc, m_next_tick;
  bit         m_err, m_armed;
  logic [8:0] exp_vec, obs_vec;

  task automatic model_reset();
    plan.delete();
    m_pend = 0; m_err = 0; m_armed = 0; m_cyc = 0; m_next_tick = 0;
  endtask

  function automatic logic [8:0] model_expect();
    bit busy, urg, start, cv, cr;
    busy  = (plan.size() != 0);
    urg   = (m_pend >= MAXP - 1);
    start = !busy && m_pend > 0 && (sched_idle || urg) && cfg_en;
    cv = 0; cr = 0;
    if (busy) begin
      cv = (plan[0] == S_PREA) || (plan[0] == S_REF);
      cr = (plan[0] == S_REF);
    end
    return {busy || start, urg, cv, cr, 4'(m_pend), m_err};
  endfunction

  task automatic model_step();
    bit busy, urg, run, tick, dec;
    int pend0, nw;
    busy  = (plan.size() != 0);
    urg   = (m_pend >= MAXP - 1);
    pend0 = m_pend;
    run   = cfg_en && (cfg_trefi != 0);
    tick  = 0;
    if (run && !m_armed) begin
      m_armed = 1; m_next_tick = m_cyc + int'(cfg_trefi);
    end else if (run && m_cyc == m_next_tick) begin
      tick = 1; m_next_tick += int'(cfg_trefi);
    end
    if (!run) m_armed = 0;
    dec = busy && plan[0] == S_REF && cmd_ready;
    if (tick && !dec) begin
      if (m_pend == MAXP) m_err = 1; else m_pend++;
    end else if (dec && !tick && m_pend > 0) m_pend--;
    if (!busy) begin
      if (pend0 > 0 && (sched_idle || urg) && cfg_en) plan.push_back(S_DRAIN);
    end else begin
      case (plan[0])
        S_DRAIN: begin
          void'(plan.pop_front());
          plan.push_back(bank_open ? S_PREA : S_REF);
        end
        S_PREA: if (cmd_ready) begin
          void'(plan.pop_front());
          nw = (cfg_trp == 0) ? 1 : int'(cfg_trp);
          repeat (nw) plan.push_back(S_WAIT);
          plan.push_back(S_REF);
        end
        S_REF: if (cmd_ready) begin
          void'(plan.pop_front());
          nw = (cfg_trfc == 0) ? 1 : int'(cfg_trfc);
          repeat (nw - 1) plan.push_back(S_WAIT);
          plan.push_back(S_RFC_LAST);
        end
        S_WAIT: void'(plan.pop_front());
        default: begin
          void'(plan.pop_front());
          if (pend0 > 0 && urg) plan.push_back(S_REF);
        end
      endcase
    end
    m_cyc++;
  endtask

  task automatic set_cfg(input bit en, input int trefi, input int trfc, input int trp);
    cfg_en = en; cfg_trefi = 16'(trefi); cfg_trfc = 10'(trfc); cfg_trp = 6'(trp);
  endtask

  task automatic apply_reset();
    core_arstn = 1'b0;
    repeat (2) @(posedge core_clk);
    #2 core_arstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    set_cfg(1, 100, 20, 5); sched_idle = 1; bank_open = 1; cmd_ready = 1;
    core_arstn = 1'b0;
    @(negedge core_clk);
    obs_vec = {ref_block, ref_urgent, cmd_valid, cmd_is_ref, ref_pending, err_overflow};
    n_checks++;
    if (obs_vec !== 9'd0) $display("FAIL reset_state got=%b want=%b", obs_vec, 9'd0);
    else n_pass++;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge core_clk);
      exp_vec = model_expect();
      obs_vec = {ref_block, ref_urgent, cmd_valid, cmd_is_ref, ref_pending, err_overflow};
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL post_reset cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      else n_pass++;
      @(posedge core_clk); model_step(); #1;
    end
  endtask

  task automatic test_periodic();
    int blk = 0, n_prea = 0, n_ref = 0, first = -1;
    set_cfg(1, 100, 20, 5); sched_idle = 1; bank_open = 1; cmd_ready = 1;
    apply_reset();
    for (int i = 0; i < 250; i++) begin
      @(negedge core_clk);
      exp_vec = model_expect();
      obs_vec = {ref_block, ref_urgent, cmd_valid, cmd_is_ref, ref_pending, err_overflow};
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL periodic cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      else n_pass++;
      if (ref_block) blk++;
      if (cmd_valid && !cmd_is_ref) n_prea++;
      if (cmd_valid && cmd_is_ref) n_ref++;
      if (first < 0 && ref_pending != 0) first = i;
      @(posedge core_clk); model_step(); #1;
    end
    n_checks++;
    if (first !== 101) $display("FAIL periodic_first_debt cyc got=%0d want=101", first); else n_pass++;
    n_checks++;
    if (blk !== 58) $display("FAIL periodic_block_cycles got=%0d want=58", blk); else n_pass++;
    n_checks++;
    if (n_prea !== 2 || n_ref !== 2)
      $display("FAIL periodic_cmds got=%0d/%0d want=2/2", n_prea, n_ref);
    else n_pass++;
    n_checks++;
    if (ref_pending !== 4'd0) $display("FAIL periodic_debt_end got=%0d want=0", ref_pending);
    else n_pass++;
  endtask

  task automatic test_urgent();
    int max_p = 0, n_prea = 0, n_ref = 0;
    set_cfg(1, 10, 3, 5); sched_idle = 0; bank_open = 1; cmd_ready = 1;
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      @(negedge core_clk);
      exp_vec = model_expect();
      obs_vec = {ref_block, ref_urgent, cmd_valid, cmd_is_ref, ref_pending, err_overflow};
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL urgent cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      else n_pass++;
      if (int'(ref_pending) > max_p) max_p = int'(ref_pending);
      if (cmd_valid && !cmd_is_ref) n_prea++;
      if (cmd_valid && cmd_is_ref) n_ref++;
      @(posedge core_clk); model_step(); #1;
    end
    n_checks++;
    if (max_p !== 7) $display("FAIL urgent_max_debt got=%0d want=7", max_p); else n_pass++;
    n_checks++;
    if (!(n_ref > n_prea)) $display("FAIL urgent_back_to_back ref=%0d prea=%0d want ref>prea", n_ref, n_prea);
    else n_pass++;
  endtask

  task automatic test_overflow();
    set_cfg(1, 5, 20, 5); sched_idle = 1; bank_open = 0; cmd_ready = 0;
    apply_reset();
    for (int i = 0; i < 120; i++) begin
      cmd_ready = (i >= 60);
      @(negedge core_clk);
      exp_vec = model_expect();
      obs_vec = {ref_block, ref_urgent, cmd_valid, cmd_is_ref, ref_pending, err_overflow};
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL overflow cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      else n_pass++;
      if (i >= 8 && i <= 60) begin
        n_checks++;
        if ({cmd_valid, cmd_is_ref} !== 2'b11)
          $display("FAIL overflow_cmd_stable cyc=%0d got=%b want=11", i, {cmd_valid, cmd_is_ref});
        else n_pass++;
      end
      if (i == 59) begin
        n_checks++;
        if ({ref_pending, err_overflow} !== {4'd8, 1'b1})
          $display("FAIL overflow_saturate got=%0d/%b want=8/1", ref_pending, err_overflow);
        else n_pass++;
      end
      @(posedge core_clk); model_step(); #1;
    end
  endtask

  task automatic test_coincident();
    set_cfg(1, 5, 20, 5); sched_idle = 1; bank_open = 0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      cmd_ready = (i == 20);
      @(negedge core_clk);
      exp_vec = model_expect();
      obs_vec = {ref_block, ref_urgent, cmd_valid, cmd_is_ref, ref_pending, err_overflow};
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL coincident cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      else n_pass++;
      if (i == 21) begin
        n_checks++;
        if (ref_pending !== 4'd3) $display("FAIL coincident_debt got=%0d want=3", ref_pending);
        else n_pass++;
      end
      @(posedge core_clk); model_step(); #1;
    end
  endtask

  task automatic test_no_bank();
    int n_prea = 0;
    set_cfg(1, 50, 4, 3); sched_idle = 1; bank_open = 0; cmd_ready = 1;
    apply_reset();
    for (int i = 0; i < 70; i++) begin
      @(negedge core_clk);
      exp_vec = model_expect();
      obs_vec = {ref_block, ref_urgent, cmd_valid, cmd_is_ref, ref_pending, err_overflow};
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL no_bank cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      else n_pass++;
      if (cmd_valid && !cmd_is_ref) n_prea++;
      if (i == 53) begin
        n_checks++;
        if ({cmd_valid, cmd_is_ref} !== 2'b11)
          $display("FAIL no_bank_direct_ref got=%b want=11", {cmd_valid, cmd_is_ref});
        else n_pass++;
      end
      @(posedge core_clk); model_step(); #1;
    end
    n_checks++;
    if (n_prea !== 0) $display("FAIL no_bank_prea_count got=%0d want=0", n_prea); else n_pass++;
  endtask

  task automatic test_async_reset();
    set_cfg(1, 100, 20, 5); sched_idle = 1; bank_open = 1; cmd_ready = 1;
    apply_reset();
    for (int i = 0; i < 135; i++) begin
      if (i == 115) begin
        #2 core_arstn = 1'b0;
        #1;
        obs_vec = {ref_block, ref_urgent, cmd_valid, cmd_is_ref, ref_pending, err_overflow};
        n_checks++;
        if (obs_vec !== 9'd0) $display("FAIL async_reset_outputs got=%b want=%b", obs_vec, 9'd0);
        else n_pass++;
        @(posedge core_clk);
        #2 core_arstn = 1'b1;
        model_reset();
      end
      @(negedge core_clk);
      exp_vec = model_expect();
      obs_vec = {ref_block, ref_urgent, cmd_valid, cmd_is_ref, ref_pending, err_overflow};
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL async_reset cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      else n_pass++;
      @(posedge core_clk); model_step(); #1;
    end
  endtask

  task automatic test_cfg_en_drop();
    set_cfg(1, 20, 20, 5); sched_idle = 1; bank_open = 1; cmd_ready = 0;
    apply_reset();
    for (int i = 0; i < 130; i++) begin
      cfg_en = (i < 65);
      cmd_ready = (i >= 70);
      @(negedge core_clk);
      exp_vec = model_expect();
      obs_vec = {ref_block, ref_urgent, cmd_valid, cmd_is_ref, ref_pending, err_overflow};
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL cfg_en_drop cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      else n_pass++;
      @(posedge core_clk); model_step(); #1;
    end
    n_checks++;
    if ({ref_pending, ref_block, cmd_valid} !== {4'd2, 1'b0, 1'b0})
      $display("FAIL cfg_en_drop_end got=%0d/%b/%b want=2/0/0", ref_pending, ref_block, cmd_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      set_cfg(1, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(2, 25),
              $urandom_range(0, 12), $urandom_range(0, 6));
      apply_reset();
      for (int i = 0; i < 1500; i++) begin
        sched_idle = ($urandom_range(0, 3) != 0);
        bank_open  = $urandom_range(0, 1) == 1;
        cmd_ready  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) == 0) cfg_en = ~cfg_en;
        if ($urandom_range(0, 19) == 0) cfg_trp = 6'($urandom_range(0, 6));
        if ($urandom_range(0, 19) == 0) cfg_trfc = 10'($urandom_range(0, 12));
        @(negedge core_clk);
        exp_vec = model_expect();
        obs_vec = {ref_block, ref_urgent, cmd_valid, cmd_is_ref, ref_pending, err_overflow};
        n_checks++;
        if (obs_vec !== exp_vec)
          $display("FAIL random run=%0d cyc=%0d got=%b want=%b", r, i, obs_vec, exp_vec);
        else n_pass++;
        @(posedge core_clk); model_step(); #1;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_periodic();
    test_urgent();
    test_overflow();
    test_coincident();
    test_no_bank();
    test_async_reset();
    test_cfg_en_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
